// File: rtl/host_read_port.sv
// Host-bus read port: local producer fills a FIFO, the asynchronous host bus drains it and reads status/count.
// Optional feature macro: HOST_READ_IRQ_EN builds the count-threshold interrupt (irq and status bit4).
module host_read_port #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int IRQ_LEVEL = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             host_cs_n,
  input  logic             host_rd_n,
  input  logic [1:0]       host_address,
  output logic [WIDTH-1:0] host_data_out,
  output logic             host_data_oe,
  output logic             irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("host_read_port: DEPTH must be a power of two >= 2");
  end
  if (WIDTH < 5 || WIDTH < CW) begin : g_bad_width
    $error("host_read_port: WIDTH too small for status/count");
  end
  if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
    $error("host_read_port: IRQ_LEVEL out of range 1..DEPTH");
  end

  logic [1:0]       cs_sync;
  logic [1:0]       rd_sync;
  logic [1:0]       addr_sync1;
  logic [1:0]       addr_s;
  logic [1:0]       sync_fill;
  logic             strobe_s;
  logic             strobe_prev;
  logic             strobe_rise;
  logic             strobe_fall;
  logic             armed;
  logic [1:0]       rd_addr;
  logic             rd_done;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             empty;
  logic             full;
  logic             push_acc;
  logic             pop;
  logic             set_ovf;
  logic             set_unf;
  logic             clr_sticky;
  logic             irq_r;
  logic [WIDTH-1:0] rd_mux;

  assign host_data_oe = !host_cs_n & !host_rd_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      cs_sync    <= '1;
      rd_sync    <= '1;
      addr_sync1 <= '0;
      addr_s     <= '0;
    end else begin
      cs_sync    <= {cs_sync[0], host_cs_n};
      rd_sync    <= {rd_sync[0], host_rd_n};
      addr_sync1 <= host_address;
      addr_s     <= addr_sync1;
    end
  end

  assign strobe_s    = !cs_sync[1] & !rd_sync[1];
  assign strobe_rise = strobe_s & !strobe_prev;
  assign strobe_fall = !strobe_s & strobe_prev;
  assign rd_done     = strobe_fall & armed;

  // strobe_prev is held "active" until the synchronisers have refilled after reset,
  // so a strobe already low at reset release never looks like a fresh rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_fill   <= '0;
      strobe_prev <= 1'b1;
      armed       <= 1'b0;
      rd_addr     <= '0;
    end else begin
      sync_fill   <= {sync_fill[0], 1'b1};
      strobe_prev <= sync_fill[1] ? strobe_s : 1'b1;
      if (strobe_rise) begin
        armed   <= 1'b1;
        rd_addr <= addr_s;
      end else if (rd_done) begin
        armed <= 1'b0;
      end
    end
  end

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign push_ready = !full;
  assign push_acc   = push_valid & !full;
  assign pop        = rd_done & (rd_addr == 2'd0) & !empty;
  assign set_ovf    = push_valid & full;
  assign set_unf    = rd_done & (rd_addr == 2'd0) & empty;
  assign clr_sticky = rd_done & (rd_addr == 2'd1);

  always_ff @(posedge clock) begin
    if (push_acc) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      case ({push_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= set_ovf | (overflow & !clr_sticky);
      underflow <= set_unf | (underflow & !clr_sticky);
    end
  end

`ifdef HOST_READ_IRQ_EN
  always_ff @(posedge clock) begin
    if (reset) irq_r <= 1'b0;
    else       irq_r <= (count >= CW'(IRQ_LEVEL));
  end
`else
  assign irq_r = 1'b0;
`endif

  assign irq = irq_r;

  always_comb begin
    rd_mux = '0;
    case (addr_s)
      2'd0:    rd_mux = empty ? '0 : mem[rd_ptr];
      2'd1:    rd_mux = WIDTH'({irq_r, underflow, overflow, full, empty});
      2'd2:    rd_mux = WIDTH'(count);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) host_data_out <= '0;
    else       host_data_out <= rd_mux;
  end

endmodule

// File: tb/tb_host_read_port.sv
// Scoreboard bench for host_read_port: a queue model of the FIFO predicts each host read.
module tb_host_read_port;

`ifdef HOST_READ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       push_valid;
  logic [7:0] push_data;
  logic       push_ready;
  logic       host_cs_n;
  logic       host_rd_n;
  logic [1:0] host_address;
  logic [7:0] host_data_out;
  logic       host_data_oe;
  logic       irq;

  int vectors;
  int miscompares;

  logic [7:0] mq[$];
  logic       m_ovf;
  logic       m_unf;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  host_read_port #(.WIDTH(8), .DEPTH(16), .IRQ_LEVEL(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .host_cs_n    (host_cs_n),
    .host_rd_n    (host_rd_n),
    .host_address (host_address),
    .host_data_out(host_data_out),
    .host_data_oe (host_data_oe),
    .irq          (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [1:0] a);
    logic irq_b, full_b, empty_b;
    irq_b   = IRQ_ON && (mq.size() >= 8);
    full_b  = (mq.size() == 16);
    empty_b = (mq.size() == 0);
    case (a)
      2'd0:    return empty_b ? 8'h00 : mq[0];
      2'd1:    return {3'b000, irq_b, m_unf, m_ovf, full_b, empty_b};
      2'd2:    return 8'(mq.size());
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_read_effect(input logic [1:0] a);
    if (a == 2'd0) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_unf = 1'b1;
    end else if (a == 2'd1) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clock);
    push_valid = 1'b1;
    push_data  = d;
    @(negedge clock);
    push_valid = 1'b0;
    if (mq.size() < 16) mq.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic strobe_on(input logic [1:0] a, input string tag);
    exp_q.push_back(exp_read(a));
    tag_q.push_back(tag);
    @(negedge clock);
    host_address = a;
    host_cs_n    = 1'b0;
    host_rd_n    = 1'b0;
    repeat (4) @(negedge clock);
    check("oe_active", 32'(host_data_oe), 32'd1);
    check(tag_q.pop_front(), 32'(host_data_out), 32'(exp_q.pop_front()));
    host_cs_n = 1'b1;
    host_rd_n = 1'b1;
  endtask

  task automatic host_read(input logic [1:0] a, input string tag);
    strobe_on(a, tag);
    model_read_effect(a);
    repeat (5) @(negedge clock);
  endtask

  // Push lands on the same edge as the pop: third rising edge after strobe release.
  task automatic host_read_push(input logic [1:0] a, input string tag, input logic [7:0] d);
    bit full_pre;
    strobe_on(a, tag);
    full_pre = (mq.size() == 16);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    push_valid = 1'b1;
    push_data  = d;
    @(negedge clock);
    push_valid = 1'b0;
    model_read_effect(a);
    if (full_pre) m_ovf = 1'b1;
    else mq.push_back(d);
    repeat (4) @(negedge clock);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    push_valid = 1'b0;
    push_data = '0;
    host_cs_n = 1'b1;
    host_rd_n = 1'b1;
    host_address = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_data", 32'(host_data_out), 32'h0);
    check("rst_ready", 32'(push_ready), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_oe", 32'(host_data_oe), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    host_read(2'd1, "rst_status");
    host_read(2'd2, "rst_count");

    // Two bytes, then address-to-data latency of three edges
    push_byte(8'hA5);
    push_byte(8'h3C);
    host_address = 2'd2;
    repeat (5) @(negedge clock);
    host_address = 2'd1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("lat_old", 32'(host_data_out), 32'h02);
    @(negedge clock);
    check("lat_new", 32'(host_data_out), 32'(exp_read(2'd1)));
    host_read(2'd0, "head_a5");
    host_read(2'd0, "head_3c");
    host_read(2'd1, "after_drain");

    // Fill, overflow, sticky clear, drain, wrap
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("full_ready", 32'(push_ready), 32'd0);
    push_byte(8'hFF);
    repeat (2) @(negedge clock);
    check("full_irq", 32'(irq), 32'(IRQ_ON));
    host_read(2'd1, "ovf_status");
    host_read(2'd1, "ovf_cleared");
    for (int i = 0; i < 16; i++) host_read(2'd0, "drain");
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(8'h40 + i));
      host_read(2'd0, "wrap_pair");
    end

    // Underflow
    host_read(2'd0, "empty_head");
    host_read(2'd2, "empty_count");
    host_read(2'd1, "unf_status");
    host_read(2'd1, "unf_cleared");

    // Push coinciding with pop: at full, and at count 5
    for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
    host_read_push(2'd0, "full_pp_head", 8'hEE);
    host_read(2'd2, "full_pp_count");
    host_read(2'd1, "full_pp_status");
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(8'(8'h20 + i));
    host_read_push(2'd0, "c5_pp_head", 8'h77);
    host_read(2'd2, "c5_pp_count");
    for (int i = 0; i < 5; i++) host_read(2'd0, "c5_drain");

    // Reset mid-operation discards contents
    for (int i = 0; i < 3; i++) push_byte(8'(8'h60 + i));
    do_reset();
    host_read(2'd2, "rst_mid_count");

    // Strobe held low across reset release must not pop
    @(negedge clock);
    host_address = 2'd0;
    host_cs_n = 1'b0;
    host_rd_n = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 3; i++) push_byte(8'(8'h90 + i));
    repeat (3) @(negedge clock);
    host_cs_n = 1'b1;
    host_rd_n = 1'b1;
    repeat (6) @(negedge clock);
    host_read(2'd2, "held_count");
    host_read(2'd1, "held_status");

    // IRQ threshold boundary
    do_reset();
    for (int i = 0; i < 7; i++) push_byte(8'(i));
    repeat (2) @(negedge clock);
    check("irq_below", 32'(irq), 32'd0);
    push_byte(8'h07);
    repeat (2) @(negedge clock);
    check("irq_at_level", 32'(irq), 32'(IRQ_ON));
    host_read(2'd1, "irq_status");
    host_read(2'd3, "addr3_zero");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/host_read_port.md
# host_read_port

Host-bus read-side companion to the host write register file. Local logic pushes bytes into an internal FIFO, and the host CPU drains them through the same asynchronous `host_cs_n` / `address` bus. The host can also read FIFO status and count. All host strobes are synchronised into the single `clock` domain; the FIFO pop and the sticky-status clear happen on the synchronised end of the read strobe.

## Interface
Parameters:
- `WIDTH`, 8: data width. Must be ≥ `$clog2(DEPTH+1)` and ≥ 5.
- `DEPTH`, 16: FIFO entries. Power of two, ≥ 2.
- `IRQ_LEVEL`, 8: `irq` asserts when count ≥ this value. Range 1..`DEPTH`.

Ports:
- `clock` in 1: sole clock; all state is updated on its rising edge.
- `reset` in 1: synchronous, active-high. Clears all state.
- `push_valid` in 1: local producer offers `push_data`.
- `push_data` in `WIDTH`: byte to enqueue.
- `push_ready` out 1: `!full`, decoded from registered count.
- `host_cs_n` in 1: host chip select, active-low, asynchronous.
- `host_rd_n` in 1: host read strobe, active-low, asynchronous.
- `host_address` in 2: register select. Must be stable while `host_rd_n` is low.
- `host_data_out` out `WIDTH`: registered read data.
- `host_data_oe` out 1: combinational `!host_cs_n & !host_rd_n`. Drives the external tristate.
- `irq` out 1: level interrupt to host.

## Operation
- Each of `host_cs_n`, `host_rd_n` and `host_address` passes through a 2-flop synchroniser. On reset the strobe flops load 1 (inactive) and the address flops load 0.
- `strobe_s` is the synchronised `!cs_n & !rd_n`.
- `armed` sets on a `strobe_s` 0→1 edge and latches the synchronised address into `rd_addr`.
- On a `strobe_s` 1→0 edge with `armed` set, a one-cycle `rd_done` pulse is generated and `armed` clears. A strobe that was already active when reset released never produces `rd_done`.
- Register map for `host_data_out`, updated every cycle from the synchronised address:
  - 0: FIFO head entry; 0 when empty.
  - 1: status. bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky), bit4 `irq`. Other bits 0.
  - 2: count, zero-extended.
  - 3: constant 0.
- `rd_done` with `rd_addr`==0:
  - Not empty: pop (read pointer +1, count −1).
  - Empty: no pop; set underflow.
- `rd_done` with `rd_addr`==1: clear overflow and underflow. If a new overflow occurs in the same cycle, set wins.
- Push is accepted when `push_valid & push_ready`. `push_valid` while full drops the data and sets overflow.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - When full, the push is rejected even if a pop occurs that cycle, because `push_ready` is decided from the pre-pop count.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Count is `$clog2(DEPTH+1)` bits and saturates at neither end, because the guards above prevent it.
- `irq` = registered (count ≥ `IRQ_LEVEL`).

## Timing
- Reset values:
  - `push_ready` 1.
  - `host_data_out` 0.
  - `irq` 0.
  - Count, pointers, sticky bits and `armed` all 0.
  - `host_data_oe` follows its inputs asynchronously.
- Push at edge N: count, status and head reflect it at `host_data_out` after edge N+1.
- Host address change: `host_data_out` is valid 3 `clock` edges later (2 synchroniser + 1 output register). The host read access time must cover 3 clock periods.
- Strobe release to pop: the pop occurs 3 edges after the release (2 synchroniser, 1 edge detect). The new head is visible 1 edge after that.
- Minimum host strobe low time and minimum gap between strobes: 3 clock periods each.
- Reset asserted mid-operation: all FIFO contents are discarded. The next host read of address 2 returns 0.

## Configuration
- `HOST_READ_IRQ_EN`:
  - Defined: the `irq` logic is built as above, and status bit4 mirrors `irq`.
  - Undefined: `irq` is tied 0, status bit4 reads 0, and the comparator and its register are not instantiated. `IRQ_LEVEL` is ignored.

## Test plan
- Reset, then host reads addr 1 → `0x01` (empty); addr 2 → `0x00`; `push_ready`=1; `irq`=0.
- Push `0xA5`, `0x3C`; host reads addr 0 twice → `0xA5` then `0x3C`; then addr 1 → `0x01`.
- Push 16 bytes `0x00`..`0x0F`, then `0xFF` while full → `push_ready`=0. Addr 1 reads `0x16` (full, overflow, irq). A second addr 1 read → `0x12`. Draining returns `0x00`..`0x0F`, proving pointer wrap after a further 16 push/pop pairs.
- Host read of addr 0 while empty → data 0, count stays 0; next addr 1 read → `0x09` (empty, underflow); following read → `0x01`.
- At full, push and pop in the same cycle → count 16→15, pushed byte dropped, overflow set. At count 5, the same pattern → count stays 5.
- Hold the strobe low across reset release, then release it → no pop, count unchanged. With `HOST_READ_IRQ_EN` undefined, 8 pushes → `irq`=0 and status bit4=0.
